// File: rtl/fixed_mult_pipe_if.sv
// Operand/result handshake bundle for fixed_mult_pipe.
// Latency: none (wires only).
// Backpressure: data_ready_o/data_ready_i carry it in each direction.
interface fixed_mult_pipe_if #(
    parameter int DATA_W = 12
);
    logic              data_valid_i;
    logic              data_ready_o;
    logic [DATA_W-1:0] data_1_i;
    logic [DATA_W-1:0] data_2_i;
    logic              data_valid_o;
    logic              data_ready_i;
    logic [DATA_W-1:0] data_mult_o;
    logic              ovf_o;

    // Multiplier side
    modport slave (
        input  data_valid_i, data_1_i, data_2_i, data_ready_i,
        output data_ready_o, data_valid_o, data_mult_o, ovf_o
    );

    // Operand source / result sink side
    modport master (
        output data_valid_i, data_1_i, data_2_i, data_ready_i,
        input  data_ready_o, data_valid_o, data_mult_o, ovf_o
    );
endinterface

// File: rtl/fixed_mult_pipe.sv
// Pipelined fixed-point multiplier with rounding, saturation and overflow flag.
// Latency: PIPE_DEPTH cycles from accepted operands to data_valid_o; 1 result/cycle.
// Backpressure: global enable; whole pipe holds while a result is valid and not accepted.
module fixed_mult_pipe #(
    parameter int DATA_W     = 12,
    parameter int FRAC_W     = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int SIGNED     = 1,
    parameter int ROUND_MODE = 1,
    parameter int SAT_EN     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fixed_mult_pipe_if.slave     bus
);

    localparam int PW   = 2 * DATA_W;
    localparam int PW1  = PW + 1;
    // Product registers between the operand stage and the round/sat stage
    localparam int NRET = PIPE_DEPTH - 2;
    localparam logic SGN = (SIGNED != 0);
    // Half-LSB of the result; zero when truncating or when there is no fraction
    localparam logic [PW:0] RND_C = (ROUND_MODE != 0 && FRAC_W > 0)
                                  ? (PW1'(1) << ((FRAC_W > 0) ? FRAC_W - 1 : 0))
                                  : '0;

    logic                  en;
    logic                  in_xfer;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]     a_q, b_q;
    logic [PW-1:0]         a_ext, b_ext, prod_c, fin_prod;
    logic [PW:0]           pr_c;
    logic signed [PW:0]    r_c;
    logic [DATA_W-1:0]     res_d, res_q;
    logic                  ovf_d, ovf_q;

    assign en               = ~vld_q[PIPE_DEPTH-1] | bus.data_ready_i;
    assign in_xfer          = bus.data_valid_i & en;
    assign bus.data_ready_o = en;
    assign bus.data_valid_o = vld_q[PIPE_DEPTH-1];
    assign bus.data_mult_o  = res_q;
    assign bus.ovf_o        = ovf_q;

    // Valid chain: shift on enable, bubbles enter as 0, hold otherwise
    always_comb begin
        vld_d = vld_q;
        if (en) begin
            vld_d = {vld_q[PIPE_DEPTH-2:0], in_xfer};
        end
    end

    // Valid chain register; reset flushes everything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            a_q <= bus.data_1_i;
            b_q <= bus.data_2_i;
        end
    end

    // Full-width product; sign extension first makes the low 2*DATA_W bits exact
    always_comb begin
        a_ext  = {{DATA_W{SGN & a_q[DATA_W-1]}}, a_q};
        b_ext  = {{DATA_W{SGN & b_q[DATA_W-1]}}, b_q};
        prod_c = a_ext * b_ext;
    end

    generate
        if (NRET == 0) begin : g_noret
            assign fin_prod = prod_c;
        end else begin : g_ret
            logic [PW-1:0] ret_q [NRET];

            // Product register followed by retiming registers
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < NRET; i++) begin
                        ret_q[i] <= '0;
                    end
                end else if (en) begin
                    ret_q[0] <= prod_c;
                    for (int i = 1; i < NRET; i++) begin
                        ret_q[i] <= ret_q[i-1];
                    end
                end
            end

            assign fin_prod = ret_q[NRET-1];
        end
    endgenerate

    // Round in one extra bit so the add cannot wrap, shift, then range-check and clamp
    always_comb begin
        pr_c  = {SGN & fin_prod[PW-1], fin_prod} + RND_C;
        r_c   = $signed(pr_c) >>> FRAC_W;
        res_d = r_c[DATA_W-1:0];
        ovf_d = 1'b0;
        if (SGN) begin
            // In range only when all bits from the sign position upward agree
            ovf_d = ~((&r_c[PW:DATA_W-1]) | ~(|r_c[PW:DATA_W-1]));
            if (ovf_d && SAT_EN != 0) begin
                res_d = r_c[PW] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            // Unsigned result is never negative, so only the top bound matters
            ovf_d = |r_c[PW:DATA_W];
            if (ovf_d && SAT_EN != 0) begin
                res_d = '1;
            end
        end
    end

    // Final stage: result and overflow registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

endmodule
